ball_motion_ctrl: RTL and testbench

Frame-rate motion controller for the on-screen ball. It recovers a one-cycle frame tick from the VGA vertical sync in the pixel-clock domain and runs a serve/move/pause state machine. Its datapath steps the ball position with independent horizontal and vertical speed dividers and reflects the ball at the visible-area edges. It sits between the VGA timing generator and the ball renderer, driving the renderer's position inputs, and replaces per-module VSync-clocked logic with a single-clock design.

---
 rtl/ball_motion_ctrl.sv | 143 ++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ball_motion_ctrl: VSync-derived frame tick plus serve/move/pause ball FSM |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ball_motion_ctrl #(
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int BALL_SIZE    = 10,
  parameter int SERVE_FRAMES = 60,
  parameter int H_STEP_DIV   = 1,
  parameter int V_STEP_DIV   = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_VSync,
  input  logic       i_Start,
  input  logic       i_Pause,
  output logic [9:0] o_Ball_X,
  output logic [9:0] o_Ball_Y,
  output logic       o_Bounce_X,
  output logic       o_Bounce_Y,
  output logic       o_Frame_Tick,
  output logic [1:0] o_State
);

  localparam logic [9:0] X_MAX = 10'(H_VISIBLE - BALL_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_VISIBLE - BALL_SIZE);
  localparam logic [9:0] X_CTR = 10'((H_VISIBLE - BALL_SIZE) / 2);
  localparam logic [9:0] Y_CTR = 10'((V_VISIBLE - BALL_SIZE) / 2);
  localparam int SC_W = $clog2(SERVE_FRAMES + 1);
  localparam int HC_W = (H_STEP_DIV > 1) ? $clog2(H_STEP_DIV) : 1;
  localparam int VC_W = (V_STEP_DIV > 1) ? $clog2(V_STEP_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SERVE  = 2'd1,
    S_MOVE   = 2'd2,
    S_PAUSED = 2'd3
  } state_t;

  state_t            state_q;
  logic [2:0]        vs_q;
  logic              tick_q;
  logic [9:0]        x_q, y_q;
  logic              xdir_q, ydir_q;
  logic [SC_W-1:0]   serve_cnt_q;
  logic [HC_W-1:0]   hcnt_q;
  logic [VC_W-1:0]   vcnt_q;
  logic              bounce_x_q, bounce_y_q;

  logic              x_hit, y_hit;
  logic              xdir_d, ydir_d;
  logic [9:0]        x_d, y_d;

  // A ball sitting on the edge it is heading into reflects: direction flips
  // and the same step moves it one pixel back inward.
  always_comb begin
    x_hit  = xdir_q ? (x_q == X_MAX) : (x_q == 10'd0);
    y_hit  = ydir_q ? (y_q == Y_MAX) : (y_q == 10'd0);
    xdir_d = xdir_q ^ x_hit;
    ydir_d = ydir_q ^ y_hit;
    x_d    = xdir_d ? (x_q + 10'd1) : (x_q - 10'd1);
    y_d    = ydir_d ? (y_q + 10'd1) : (y_q - 10'd1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= S_IDLE;
      vs_q        <= 3'b111;
      tick_q      <= 1'b0;
      x_q         <= X_CTR;
      y_q         <= Y_CTR;
      xdir_q      <= 1'b1;
      ydir_q      <= 1'b1;
      serve_cnt_q <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      bounce_x_q  <= 1'b0;
      bounce_y_q  <= 1'b0;
    end else begin
      vs_q       <= {vs_q[1:0], i_VSync};
      tick_q     <= vs_q[2] & ~vs_q[1];
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      if (i_Start) begin
        state_q     <= S_SERVE;
        x_q         <= X_CTR;
        y_q         <= Y_CTR;
        xdir_q      <= ~xdir_q;
        ydir_q      <= 1'b1;
        serve_cnt_q <= '0;
        hcnt_q      <= '0;
        vcnt_q      <= '0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_SERVE: begin
            if (tick_q) begin
              serve_cnt_q <= serve_cnt_q + 1'b1;
              if (serve_cnt_q == SC_W'(SERVE_FRAMES - 1)) state_q <= S_MOVE;
            end
          end
          S_MOVE: begin
            if (i_Pause) begin
              state_q <= S_PAUSED;
            end else if (tick_q) begin
              if (hcnt_q == HC_W'(H_STEP_DIV - 1)) begin
                hcnt_q     <= '0;
                x_q        <= x_d;
                xdir_q     <= xdir_d;
                bounce_x_q <= x_hit;
              end else begin
                hcnt_q <= hcnt_q + 1'b1;
              end
              if (vcnt_q == VC_W'(V_STEP_DIV - 1)) begin
                vcnt_q     <= '0;
                y_q        <= y_d;
                ydir_q     <= ydir_d;
                bounce_y_q <= y_hit;
              end else begin
                vcnt_q <= vcnt_q + 1'b1;
              end
            end
          end
          S_PAUSED: begin
            if (!i_Pause) state_q <= S_MOVE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_Ball_X     = x_q;
  assign o_Ball_Y     = y_q;
  assign o_Bounce_X   = bounce_x_q;
  assign o_Bounce_Y   = bounce_y_q;
  assign o_Frame_Tick = tick_q;
  assign o_State      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ball_motion_ctrl: directed + random bench with an event-level model   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ball_motion_ctrl;

  localparam int H    = 40;
  localparam int V    = 30;
  localparam int B    = 10;
  localparam int SF   = 3;
  localparam int HD   = 1;
  localparam int VD   = 2;
  localparam int XMAX = H - B;
  localparam int YMAX = V - B;
  localparam int XC   = (H - B) / 2;
  localparam int YC   = (V - B) / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] bx_o, by_o;
  logic       bnx_o, bny_o, tick_o;
  logic [1:0] st_o;

  int checks = 0;
  int errors = 0;

  // Event-level reference: ball state changes only on start, pause edges and ticks.
  int m_state, m_x, m_y, m_xd, m_yd, m_sc, m_hc, m_vc;
  bit pause_lvl;

  always #5 clk = ~clk;

  ball_motion_ctrl #(
    .H_VISIBLE(H), .V_VISIBLE(V), .BALL_SIZE(B),
    .SERVE_FRAMES(SF), .H_STEP_DIV(HD), .V_STEP_DIV(VD)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_VSync(vsync), .i_Start(start),
    .i_Pause(pause), .o_Ball_X(bx_o), .o_Ball_Y(by_o), .o_Bounce_X(bnx_o),
    .o_Bounce_Y(bny_o), .o_Frame_Tick(tick_o), .o_State(st_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit ebx, input bit eby);
    chk({tag, ".x"}, 32'(bx_o), 32'(m_x));
    chk({tag, ".y"}, 32'(by_o), 32'(m_y));
    chk({tag, ".state"}, 32'(st_o), 32'(m_state));
    chk({tag, ".bounce_x"}, 32'(bnx_o), 32'(ebx));
    chk({tag, ".bounce_y"}, 32'(bny_o), 32'(eby));
  endtask

  function automatic int new_dir(input int p, input int d, input int mx);
    return (p + d > mx || p + d < 0) ? -d : d;
  endfunction

  task automatic m_reset();
    m_state = 0; m_x = XC; m_y = YC; m_xd = 1; m_yd = 1;
    m_sc = 0; m_hc = 0; m_vc = 0;
  endtask

  task automatic m_start();
    m_state = 1; m_x = XC; m_y = YC; m_xd = -m_xd; m_yd = 1;
    m_sc = 0; m_hc = 0; m_vc = 0;
  endtask

  task automatic m_tick(output bit ebx, output bit eby);
    int nd;
    ebx = 0; eby = 0;
    if (m_state == 1) begin
      m_sc++;
      if (m_sc == SF) m_state = 2;
    end else if (m_state == 2) begin
      m_hc = (m_hc + 1) % HD;
      if (m_hc == 0) begin
        nd = new_dir(m_x, m_xd, XMAX); ebx = (nd != m_xd); m_xd = nd; m_x += nd;
      end
      m_vc = (m_vc + 1) % VD;
      if (m_vc == 0) begin
        nd = new_dir(m_y, m_yd, YMAX); eby = (nd != m_yd); m_yd = nd; m_y += nd;
      end
    end
  endtask

  task automatic tick_evt();
    bit ebx, eby;
    @(negedge clk) vsync = 1'b0;
    repeat (3) @(negedge clk);
    chk("frame_tick_hi", 32'(tick_o), 32'd1);
    @(negedge clk) vsync = 1'b1;
    m_tick(ebx, eby);
    check_outs("tick", ebx, eby);
    @(negedge clk);
    chk("frame_tick_lo", 32'(tick_o), 32'd0);
    chk("bounce_x_pulse", 32'(bnx_o), 32'd0);
    chk("bounce_y_pulse", 32'(bny_o), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_pause(input bit v);
    @(negedge clk) pause = v;
    pause_lvl = v;
    @(negedge clk);
    if (m_state == 2 && v) m_state = 3;
    else if (m_state == 3 && !v) m_state = 2;
    check_outs("pause", 1'b0, 1'b0);
  endtask

  task automatic start_evt(input bit with_tick);
    if (pause_lvl) set_pause(1'b0);
    if (with_tick) begin
      @(negedge clk) vsync = 1'b0;
      repeat (3) @(negedge clk);
      chk("frame_tick_hi", 32'(tick_o), 32'd1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      vsync = 1'b1;
      m_start();
      check_outs("start_tick", 1'b0, 1'b0);
      repeat (3) @(negedge clk);
    end else begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      m_start();
      check_outs("start", 1'b0, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r;
    m_reset();
    pause_lvl = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("reset", 1'b0, 1'b0);
    chk("reset.frame_tick", 32'(tick_o), 32'd0);

    // IDLE ignores pause and ticks
    set_pause(1'b1);
    set_pause(1'b0);
    tick_evt();

    // Serve: ball stays centred through the serve, including the final tick
    start_evt(1'b0);
    repeat (SF) tick_evt();
    chk("serve_done.x", 32'(bx_o), 32'(XC));

    // Move with bounces, then pause across several ticks
    repeat (20) tick_evt();
    set_pause(1'b1);
    repeat (5) tick_evt();
    set_pause(1'b0);
    repeat (3) tick_evt();

    // Start coincident with a tick in MOVE
    start_evt(1'b1);

    // Asynchronous reset between clock edges while serving
    tick_evt();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_outs("async_reset", 1'b0, 1'b0);
    chk("async_reset.frame_tick", 32'(tick_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Long VSync low yields one tick
    cnt = 0;
    @(negedge clk) vsync = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cnt += int'(tick_o);
    end
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    chk("long_vsync_ticks", 32'(cnt), 32'd1);
    check_outs("long_vsync", 1'b0, 1'b0);

    // Randomized event sequence
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (m_state == 0) start_evt(1'($urandom_range(0, 1)));
      else if (r < 5 && m_state != 1) start_evt(1'($urandom_range(0, 1)));
      else if (r < 12 && m_state >= 2) set_pause(!pause_lvl);
      else tick_evt();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
